// File: rtl/uart_mul.sv
// iCEBreaker UART byte multiplier: receives operands A then B (8N1), returns the
// 16-bit product A*B as two 8N1 bytes, high byte first.
module uart_mul #(
   parameter int CLK_FREQ = 12_000_000,
   parameter int BAUD     = 9_600
) (
   input  logic CLK,
   input  logic BTN_N,
   input  logic RX,
   output logic TX,
   output logic LEDR_N,
   output logic LEDG_N,
   output logic P1A1,
   output logic P1A3
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD;
   localparam int CW         = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {WAIT_A, WAIT_B, SEND_HI, SEND_LO} ctl_state_t;

   // NOTE: reset asserts asynchronously but releases two clocks later, so no flop sees a runt release.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge CLK or negedge BTN_N) begin
      if (!BTN_N) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n = rst_sync_q[1];

   // [1:0] synchronise RX, [2] holds the previous synchronised sample for edge detection.
   logic [2:0] rx_sync_q;
   logic       rx_s;
   logic       rx_fall;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) rx_sync_q <= 3'b111;
      else        rx_sync_q <= {rx_sync_q[1:0], RX};
   end

   assign rx_s    = rx_sync_q[1];
   assign rx_fall = rx_sync_q[2] & ~rx_s;

   rx_state_t     rx_state_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0]    rx_bit_q;
   logic [7:0]    rx_shift_q;
   logic [7:0]    rx_data_q;
   logic          rx_valid_q;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_fall) begin
                  rx_state_q <= RX_START;
                  rx_cnt_q   <= '0;
               end
            end
            RX_START: begin
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_bit_q   <= '0;
                  rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                  else                  rx_bit_q   <= rx_bit_q + 1'b1;
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt_q == BIT_LAST) begin
                  rx_cnt_q   <= '0;
                  rx_state_q <= RX_IDLE;
                  if (rx_s) begin
                     rx_valid_q <= 1'b1;
                     rx_data_q  <= rx_shift_q;
                  end
               end else begin
                  rx_cnt_q <= rx_cnt_q + 1'b1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   ctl_state_t    state_q;
   logic [7:0]    a_q;
   logic [15:0]   p_q;
   logic [15:0]   p_d;
   logic          tx_q;
   logic [8:0]    tx_shift_q;
   logic [3:0]    tx_bit_q;
   logic [CW-1:0] tx_cnt_q;
   logic          led_r_q;
   logic          led_g_q;

   assign p_d = {8'h00, a_q} * {8'h00, rx_data_q};

   // tx_bit_q: 0 = start, 1..8 = data, 9 = stop; the shifter carries the stop bit above the data.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_A;
         a_q        <= '0;
         p_q        <= '0;
         tx_q       <= 1'b1;
         tx_shift_q <= '0;
         tx_bit_q   <= '0;
         tx_cnt_q   <= '0;
         led_r_q    <= 1'b1;
         led_g_q    <= 1'b1;
      end else begin
         case (state_q)
            WAIT_A: begin
               if (rx_valid_q) begin
                  a_q     <= rx_data_q;
                  led_r_q <= 1'b0;
                  state_q <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (rx_valid_q) begin
                  p_q        <= p_d;
                  tx_q       <= 1'b0;
                  tx_shift_q <= {1'b1, p_d[15:8]};
                  tx_bit_q   <= '0;
                  tx_cnt_q   <= '0;
                  led_r_q    <= 1'b1;
                  led_g_q    <= 1'b0;
                  state_q    <= SEND_HI;
               end
            end
            SEND_HI, SEND_LO: begin
               if (tx_cnt_q == BIT_LAST) begin
                  tx_cnt_q <= '0;
                  if (tx_bit_q == 4'd9) begin
                     tx_bit_q <= '0;
                     if (state_q == SEND_HI) begin
                        tx_q       <= 1'b0;
                        tx_shift_q <= {1'b1, p_q[7:0]};
                        state_q    <= SEND_LO;
                     end else begin
                        tx_q    <= 1'b1;
                        led_g_q <= 1'b1;
                        state_q <= WAIT_A;
                     end
                  end else begin
                     tx_q       <= tx_shift_q[0];
                     tx_shift_q <= {1'b0, tx_shift_q[8:1]};
                     tx_bit_q   <= tx_bit_q + 1'b1;
                  end
               end else begin
                  tx_cnt_q <= tx_cnt_q + 1'b1;
               end
            end
            default: state_q <= WAIT_A;
         endcase
      end
   end

   assign TX     = tx_q;
   assign P1A3   = tx_q;
   assign P1A1   = rx_s;
   assign LEDR_N = led_r_q;
   assign LEDG_N = led_g_q;

endmodule

// File: tb/tb_uart_mul.sv
// Scoreboard bench for uart_mul: a bench UART drives operands, a monitor decodes
// TX and compares each byte against the products queued at stimulus time.
module tb_uart_mul;

   localparam int CLK_FREQ = 3_200_000;
   localparam int BAUD     = 100_000;
   localparam int BIT      = CLK_FREQ / BAUD;

   logic clk   = 1'b0;
   logic btn_n = 1'b1;
   logic rx    = 1'b1;
   logic tx, ledr_n, ledg_n, p1a1, p1a3;

   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   uart_mul #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .CLK(clk), .BTN_N(btn_n), .RX(rx), .TX(tx),
      .LEDR_N(ledr_n), .LEDG_N(ledg_n), .P1A1(p1a1), .P1A3(p1a3)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      @(negedge clk);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = {8'h00, a} * {8'h00, b};
      send_byte(a, 1'b1);
      exp_q.push_back(p[15:8]);
      exp_q.push_back(p[7:0]);
      send_byte(b, 1'b1);
   endtask

   task automatic wait_results();
      int n = 0;
      while (exp_q.size() != 0 && n < 40 * BIT) begin
         @(negedge clk);
         n++;
      end
      check("results_timeout", exp_q.size(), 0);
      repeat (BIT) @(negedge clk);
      check("idle_tx", tx, 1);
      check("idle_ledg", ledg_n, 1);
      check("idle_ledr", ledr_n, 1);
   endtask

   // Measures the TX low/high/low run lengths of 0xFE followed by 0x01.
   task automatic measure_runs();
      int n = 0, lo1 = 0, hi = 0, lo2 = 0;
      while (tx !== 1'b0 && n < 20 * BIT) begin
         @(negedge clk);
         n++;
      end
      check("meas_start_seen", tx, 0);
      while (tx === 1'b0 && lo1 < 20 * BIT) begin lo1++; @(negedge clk); end
      while (tx === 1'b1 && hi  < 20 * BIT) begin hi++;  @(negedge clk); end
      while (tx === 1'b0 && lo2 < 20 * BIT) begin lo2++; @(negedge clk); end
      check("run_start_plus_d0", lo1, 2 * BIT);
      check("run_d1_to_stop", hi, 8 * BIT);
      check("run_second_start", lo2, BIT);
   endtask

   initial begin : tx_monitor
      logic [7:0] got;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            repeat (BIT / 2 - 1) @(negedge clk);
            check("tx_start_mid", tx, 0);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               got[i] = tx;
            end
            repeat (BIT) @(negedge clk);
            check("tx_stop", tx, 1);
            check("tx_expected_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("tx_byte", got, exp_q.pop_front());
         end
      end
   end

   initial begin : watchdog
      repeat (90_000) @(posedge clk);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2 btn_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_ledr", ledr_n, 1);
      check("rst_ledg", ledg_n, 1);
      check("rst_p1a1", p1a1, 1);
      check("rst_p1a3", p1a3, 1);
      btn_n = 1'b1;
      repeat (4) @(negedge clk);

      // 3 * 5, LEDR lit only between the operands
      send_byte(8'h03, 1'b1);
      check("ledr_after_a", ledr_n, 0);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h0F);
      send_byte(8'h05, 1'b1);
      check("ledr_after_b", ledr_n, 1);
      check("ledg_sending", ledg_n, 0);
      wait_results();

      // 0xFF * 0xFF with exact bit timing and gapless second byte
      send_byte(8'hFF, 1'b1);
      exp_q.push_back(8'hFE);
      exp_q.push_back(8'h01);
      fork
         measure_runs();
         send_byte(8'hFF, 1'b1);
      join
      wait_results();

      send_pair(8'h00, 8'h7B);
      wait_results();
      send_pair(8'h10, 8'h10);
      wait_results();

      // framing error between the operands is ignored
      send_byte(8'h02, 1'b1);
      send_byte(8'hA5, 1'b0);
      check("ledr_after_bad", ledr_n, 0);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h06);
      send_byte(8'h03, 1'b1);
      wait_results();

      // reset with A held discards it
      send_byte(8'h07, 1'b1);
      check("ledr_a_held", ledr_n, 0);
      @(negedge clk);
      btn_n = 1'b0;
      #1;
      check("rst_async_ledr", ledr_n, 1);
      check("rst_async_tx", tx, 1);
      @(negedge clk);
      btn_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_tx", tx, 1);
      check("post_rst_ledr", ledr_n, 1);
      send_pair(8'h04, 8'h04);
      wait_results();

      // byte arriving during transmission is dropped
      send_pair(8'h09, 8'h09);
      send_byte(8'h55, 1'b1);
      check("ledg_during_drop", ledg_n, 0);
      wait_results();
      send_pair(8'h02, 8'h02);
      wait_results();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_mul.md
Name: uart_mul

Overview:
iCEBreaker board top that implements a UART byte multiplier.
- Receives two unsigned 8-bit operands A then B on RX (8N1).
- Computes the 16-bit product A*B.
- Returns the product on TX as two 8N1 bytes, high byte first.
- Contains its own UART receiver, UART transmitter and control FSM. Default link is 9600 baud from the 12 MHz board clock.

Parameters:
CLK_FREQ, 12_000_000, input clock frequency in Hz.
BAUD, 9_600, line rate in bit/s.
BIT_CYCLES, CLK_FREQ/BAUD (integer division, 1250 by default), clocks per UART bit. Derived; must not be overridden.

Ports:
CLK  input  1  system clock, 12 MHz; all logic is clocked on its rising edge.
BTN_N  input  1  reset, asynchronous assert, active-low.
RX  input  1  UART serial input, idle high.
TX  output  1  UART serial output, idle high.
LEDR_N  output  1  active-low red LED; lit while operand A is held and B is awaited.
LEDG_N  output  1  active-low green LED; lit while a result is being transmitted.
P1A1  output  1  copy of the synchronised RX, for a logic analyser.
P1A3  output  1  copy of TX.

Behaviour:
Reset:
- BTN_N low asserts reset immediately, asynchronously. Release is synchronised to CLK (2-flop).
- In reset: TX=1, LEDR_N=1, LEDG_N=1, P1A3=1, P1A1=1.
- In reset: FSM=WAIT_A, operand and product registers cleared, all bit/baud counters cleared.
- Reset mid-frame aborts any RX or TX frame. TX returns high at once.

RX path:
- RX passes through a 2-flop synchroniser (flops reset to 1).
- Start is a falling edge while the receiver is idle.
- Start bit is re-checked at BIT_CYCLES/2. If it is high there, the event is a glitch: return to idle.
- Each data bit is sampled every BIT_CYCLES from that mid-start point, LSB first.
- Stop bit is sampled one BIT_CYCLES after data bit 7.
- Stop=1: a 1-cycle rx_valid pulse is raised with the 8-bit data.
- Stop=0: framing error. The byte is discarded with no pulse.
- After the stop-bit sample the receiver is idle and may detect the next start immediately.

Control FSM:
- WAIT_A: on rx_valid, latch A, go to WAIT_B. LEDR_N=0 while in WAIT_B.
- WAIT_B: on rx_valid, latch B; product P=A*B (16-bit unsigned, full width, no truncation); go to SEND_HI.
- SEND_HI: transmit P[15:8]; on completion go to SEND_LO.
- SEND_LO: transmit P[7:0]; on completion return to WAIT_A.
- rx_valid pulses arriving in SEND_HI or SEND_LO are dropped and have no effect on A, B or P.

TX path:
- Frame is: start (0), 8 data bits LSB first, stop (1). Each bit lasts exactly BIT_CYCLES clocks.
- The SEND_HI start bit begins no more than 2 clocks after the rx_valid for B.
- The SEND_LO start bit begins on the clock immediately after the SEND_HI stop bit ends. There is no extra idle between the two bytes.
- After the SEND_LO stop bit, TX stays high.

Timing tolerance: a transmitter clocked at 8x oversampling with prescale 156 (bit = 1248 clocks) must be received error-free. Likewise, TX output must be accepted by such a receiver.

LEDs: LEDG_N=0 throughout SEND_HI and SEND_LO, and 1 otherwise.

Test Plan:
- Reset, send 0x03 then 0x05 -> TX emits 0x00 then 0x0F; LEDR_N low only between the two received bytes.
- Send 0xFF, 0xFF -> 0xFE, 0x01; each TX bit measured as 1250 clocks; the second start bit follows the first stop bit with no gap.
- Send 0x00, 0x7B -> 0x00, 0x00. Then send 0x10, 0x10 -> 0x01, 0x00 (FSM back in WAIT_A after each result).
- Send 0x02, then a frame with stop bit forced to 0, then 0x03 -> the bad byte is ignored; result 0x00, 0x06.
- Send 0x07, assert BTN_N low for one clock, then send 0x04, 0x04 -> result 0x00, 0x10; TX high during and after reset.
- During transmission of 0x09*0x09, inject byte 0x55 -> it is dropped; the result is still 0x00, 0x51; the next pair 0x02, 0x02 yields 0x00, 0x04.
